// File: rtl/lcd_pkg.sv
// Shared types and command constants for the HD44780-style LCD sequencing blocks.
package lcd_pkg;

  typedef enum logic [3:0] {
    StWaitInit,
    StCfgIssue,
    StCfgWait,
    StClearDelay,
    StAddrIssue,
    StAddrWait,
    StCharFetch,
    StCharIssue,
    StCharWait,
    StDone,
    StIdle
  } lcd_state_e;

  localparam logic [7:0] LCD_FUNC_SET = 8'h28;
  localparam logic [7:0] LCD_ENTRY    = 8'h06;
  localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
  localparam logic [7:0] LCD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_DDRAM_L0 = 8'h80;
  localparam logic [7:0] LCD_DDRAM_L1 = 8'hC0;

  localparam logic RS_CMD  = 1'b0;
  localparam logic RS_DATA = 1'b1;

  localparam int unsigned DelayWidth = 17;

  // Configuration commands in issue order; Clear Display must be last.
  function automatic logic [7:0] cfg_cmd(input logic [1:0] idx);
    logic [7:0] cmd;
    case (idx)
      2'd0:    cmd = LCD_FUNC_SET;
      2'd1:    cmd = LCD_ENTRY;
      2'd2:    cmd = LCD_DISP_ON;
      default: cmd = LCD_CLEAR;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// Loadable down-counter that saturates at zero; expired is high while the count is zero.
module lcd_delay_counter
  import lcd_pkg::*;
#(
  parameter int unsigned Width = DelayWidth
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [Width-1:0] load_value,
  input  logic             count,
  output logic             expired
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_value;
    end else if (count && (cnt_q != '0)) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/lcd_frame_sequencer.sv
// Drives the 4-bit LCD instruction sender: configure, clear, then write both 16-char lines;
// afterwards rewrites both lines on each refresh request.
module lcd_frame_sequencer
  import lcd_pkg::*;
#(
  parameter int unsigned CLEAR_WAIT     = 82000,
  parameter int unsigned CHARS_PER_LINE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       init_done,
  input  logic       refresh,
  output logic [9:0] instr_db,
  output logic       instr_next,
  input  logic       instr_done,
  output logic [4:0] char_addr,
  input  logic [7:0] char_data,
  output logic       busy,
  output logic       frame_done
);

  // Loaded with CLEAR_WAIT-1 so CLEAR_DELAY lasts exactly CLEAR_WAIT cycles.
  localparam logic [DelayWidth-1:0] ClearLoad = DelayWidth'(CLEAR_WAIT - 1);
  localparam logic [3:0]            LastCol   = 4'(CHARS_PER_LINE - 1);

  lcd_state_e state_q, state_d;
  logic [1:0] cfg_idx_q, cfg_idx_d;
  logic       line_q, line_d;
  logic [3:0] col_q, col_d;
  logic       pending_q, pending_d;
  logic [7:0] data_q, data_d;
  logic       dly_load, dly_count, dly_expired;

  lcd_delay_counter #(
    .Width(DelayWidth)
  ) u_clear_delay (
    .clk       (clk),
    .reset     (reset),
    .load      (dly_load),
    .load_value(ClearLoad),
    .count     (dly_count),
    .expired   (dly_expired)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StWaitInit;
      cfg_idx_q <= 2'd0;
      line_q    <= 1'b0;
      col_q     <= 4'd0;
      pending_q <= 1'b0;
      data_q    <= 8'h00;
    end else begin
      state_q   <= state_d;
      cfg_idx_q <= cfg_idx_d;
      line_q    <= line_d;
      col_q     <= col_d;
      pending_q <= pending_d;
      data_q    <= data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cfg_idx_d = cfg_idx_q;
    line_d    = line_q;
    col_d     = col_q;
    dly_load  = 1'b0;
    dly_count = 1'b0;
    data_d    = (state_q == StCharIssue) ? char_data : data_q;
    // Requests during a frame coalesce into one; WAIT_INIT requests are moot.
    if (state_q == StIdle) begin
      pending_d = 1'b0;
    end else if (refresh && (state_q != StWaitInit)) begin
      pending_d = 1'b1;
    end else begin
      pending_d = pending_q;
    end
    case (state_q)
      StWaitInit: begin
        if (init_done) begin
          state_d   = StCfgIssue;
          cfg_idx_d = 2'd0;
        end
      end
      StCfgIssue: state_d = StCfgWait;
      StCfgWait: begin
        if (instr_done) begin
          if (cfg_idx_q != 2'd3) begin
            cfg_idx_d = cfg_idx_q + 2'd1;
            state_d   = StCfgIssue;
          end else begin
            dly_load = 1'b1;
            state_d  = StClearDelay;
          end
        end
      end
      StClearDelay: begin
        dly_count = 1'b1;
        if (dly_expired) begin
          line_d  = 1'b0;
          state_d = StAddrIssue;
        end
      end
      StAddrIssue: state_d = StAddrWait;
      StAddrWait: begin
        if (instr_done) begin
          col_d   = 4'd0;
          state_d = StCharFetch;
        end
      end
      StCharFetch: state_d = StCharIssue;
      StCharIssue: state_d = StCharWait;
      StCharWait: begin
        if (instr_done) begin
          if (col_q != LastCol) begin
            col_d   = col_q + 4'd1;
            state_d = StCharFetch;
          end else if (!line_q) begin
            line_d  = 1'b1;
            state_d = StAddrIssue;
          end else begin
            state_d = StDone;
          end
        end
      end
      StDone: state_d = StIdle;
      StIdle: begin
        if (refresh || pending_q) begin
          line_d  = 1'b0;
          state_d = StAddrIssue;
        end
      end
      default: state_d = StWaitInit;
    endcase
  end

  always_comb begin
    instr_db   = 10'h000;
    instr_next = 1'b0;
    busy       = 1'b1;
    frame_done = 1'b0;
    case (state_q)
      StWaitInit, StIdle: busy = 1'b0;
      StCfgIssue: begin
        instr_next = 1'b1;
        instr_db   = {RS_CMD, 1'b0, cfg_cmd(cfg_idx_q)};
      end
      StCfgWait: instr_db = {RS_CMD, 1'b0, cfg_cmd(cfg_idx_q)};
      StAddrIssue: begin
        instr_next = 1'b1;
        instr_db   = {RS_CMD, 1'b0, line_q ? LCD_DDRAM_L1 : LCD_DDRAM_L0};
      end
      StAddrWait: instr_db = {RS_CMD, 1'b0, line_q ? LCD_DDRAM_L1 : LCD_DDRAM_L0};
      StCharIssue: begin
        instr_next = 1'b1;
        instr_db   = {RS_DATA, 1'b0, char_data};
      end
      // Buffer data may move on once fetched, so the latched copy is held.
      StCharWait: instr_db = {RS_DATA, 1'b0, data_q};
      StDone: begin
        busy       = 1'b0;
        frame_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign char_addr = {line_q, col_q};

endmodule

// File: tb/tb_lcd_frame_sequencer.sv
// Directed bench for lcd_frame_sequencer with a responding sender and character buffer model.
module tb_lcd_frame_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       init_done;
  logic       refresh;
  logic [9:0] instr_db;
  logic       instr_next;
  logic       instr_done = 1'b0;
  logic [4:0] char_addr;
  logic [7:0] char_data = 8'h00;
  logic       busy;
  logic       frame_done;

  int checks = 0;
  int errors = 0;

  lcd_frame_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .init_done (init_done),
    .refresh   (refresh),
    .instr_db  (instr_db),
    .instr_next(instr_next),
    .instr_done(instr_done),
    .char_addr (char_addr),
    .char_data (char_data),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Sender answers 10 cycles after instr_next; buffer holds 'A'+addr with one-cycle latency.
  int resp_cnt = 0;
  always @(posedge clk) begin
    char_data <= 8'h41 + {3'b000, char_addr};
    if (!reset) begin
      resp_cnt   <= 0;
      instr_done <= 1'b0;
    end else begin
      instr_done <= 1'b0;
      if (instr_next) begin
        resp_cnt <= 9;
      end else if (resp_cnt != 0) begin
        resp_cnt <= resp_cnt - 1;
        if (resp_cnt == 1) instr_done <= 1'b1;
      end
    end
  end

  // Observation log, sampled mid-cycle.
  logic [9:0] cmd_q[$];
  int         cmd_cyc_q[$];
  int         done_cyc_q[$];
  int         cyc = 0;
  int         frame_cnt = 0;
  int         frame_cyc = 0;
  int         viol = 0;
  logic       busy_at_frame = 1'b0;
  logic       busy_before_frame = 1'b0;
  logic       outstanding = 1'b0;
  logic       prev_next = 1'b0;
  logic       prev_busy = 1'b0;
  logic [9:0] held_db = 10'h000;

  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      outstanding = 1'b0;
      prev_next   = 1'b0;
    end else begin
      if (outstanding && (instr_db !== held_db)) viol++;
      if (instr_done) begin
        outstanding = 1'b0;
        done_cyc_q.push_back(cyc);
      end
      if (instr_next) begin
        if (prev_next || outstanding) viol++;
        cmd_q.push_back(instr_db);
        cmd_cyc_q.push_back(cyc);
        held_db     = instr_db;
        outstanding = 1'b1;
      end
      if (frame_done) begin
        frame_cnt++;
        frame_cyc         = cyc;
        busy_at_frame     = busy;
        busy_before_frame = prev_busy;
      end
      prev_next = instr_next;
    end
    prev_busy = busy;
  end

  // j-th command of a refresh frame (address commands plus 32 characters).
  function automatic logic [9:0] frame_cmd(input int j);
    if (j == 0) return 10'h080;
    if (j == 17) return 10'h0C0;
    if (j < 17) return {2'b10, 8'h41 + 8'(j - 1)};
    return {2'b10, 8'h41 + 8'(j - 2)};
  endfunction

  task automatic pulse_refresh();
    refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    init_done = 1'b0;
    refresh = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (instr_db !== 10'h000) begin
      errors++; $display("FAIL reset_instr_db: got %h want %h", instr_db, 10'h000);
    end
    checks++;
    if (instr_next !== 1'b0) begin
      errors++; $display("FAIL reset_instr_next: got %b want 0", instr_next);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b want 0", busy);
    end
    checks++;
    if (frame_done !== 1'b0) begin
      errors++; $display("FAIL reset_frame_done: got %b want 0", frame_done);
    end
    checks++;
    if (char_addr !== 5'd0) begin
      errors++; $display("FAIL reset_char_addr: got %h want 00", char_addr);
    end
    reset = 1'b1;
    repeat (10) @(negedge clk);
    pulse_refresh();
    repeat (89) @(negedge clk);
    checks++;
    if (cmd_q.size() != 0) begin
      errors++; $display("FAIL wait_init_quiet: got %0d commands want 0", cmd_q.size());
    end
    checks++;
    if (busy !== 1'b0 || instr_db !== 10'h000) begin
      errors++; $display("FAIL wait_init_outputs: got busy=%b db=%h want 0/000", busy, instr_db);
    end
  endtask

  task automatic test_init_frame();
    logic [9:0] cfg_exp[4];
    logic [9:0] exp;
    int base = cmd_q.size();
    int dbase = done_cyc_q.size();
    int f0 = frame_cnt;
    cfg_exp[0] = 10'h028; cfg_exp[1] = 10'h006; cfg_exp[2] = 10'h00C; cfg_exp[3] = 10'h001;
    init_done = 1'b1;
    for (int i = 0; i < 90000 && frame_cnt == f0; i++) @(negedge clk);
    checks++;
    if (frame_cnt != f0 + 1) begin
      errors++; $display("FAIL init_frame_done: got %0d frames want %0d", frame_cnt - f0, 1);
    end
    checks++;
    if (cmd_q.size() - base != 38) begin
      errors++; $display("FAIL init_cmd_count: got %0d want 38", cmd_q.size() - base);
    end
    if (cmd_q.size() >= base + 38 && done_cyc_q.size() >= dbase + 38) begin
      for (int j = 0; j < 38; j++) begin
        exp = (j < 4) ? cfg_exp[j] : frame_cmd(j - 4);
        checks++;
        if (cmd_q[base + j] !== exp) begin
          errors++; $display("FAIL init_cmd[%0d]: got %h want %h", j, cmd_q[base + j], exp);
        end
      end
      checks++;
      if (cmd_cyc_q[base + 1] != done_cyc_q[dbase] + 1) begin
        errors++; $display("FAIL cfg_gap: got %0d want 1", cmd_cyc_q[base + 1] - done_cyc_q[dbase]);
      end
      checks++;
      if (cmd_cyc_q[base + 4] != done_cyc_q[dbase + 3] + 82001) begin
        errors++;
        $display("FAIL clear_wait: got %0d want 82001", cmd_cyc_q[base + 4] - done_cyc_q[dbase + 3]);
      end
      checks++;
      if (cmd_cyc_q[base + 6] != done_cyc_q[dbase + 5] + 2) begin
        errors++; $display("FAIL char_gap: got %0d want 2", cmd_cyc_q[base + 6] - done_cyc_q[dbase + 5]);
      end
      checks++;
      if (frame_cyc != done_cyc_q[dbase + 37] + 1) begin
        errors++; $display("FAIL frame_done_timing: got %0d want 1", frame_cyc - done_cyc_q[dbase + 37]);
      end
    end
    checks++;
    if (busy_at_frame !== 1'b0 || busy_before_frame !== 1'b1) begin
      errors++;
      $display("FAIL busy_fall: got at=%b before=%b want 0/1", busy_at_frame, busy_before_frame);
    end
  endtask

  task automatic test_refresh_idle();
    int base;
    int f0 = frame_cnt;
    repeat (20) @(negedge clk);
    base = cmd_q.size();
    repeat (20) @(negedge clk);
    checks++;
    if (cmd_q.size() != base || busy !== 1'b0) begin
      errors++; $display("FAIL idle_quiet: got %0d cmds busy=%b want 0/0", cmd_q.size() - base, busy);
    end
    pulse_refresh();
    for (int i = 0; i < 2000 && frame_cnt == f0; i++) @(negedge clk);
    repeat (200) @(negedge clk);
    checks++;
    if (frame_cnt != f0 + 1) begin
      errors++; $display("FAIL refresh_frames: got %0d want 1", frame_cnt - f0);
    end
    checks++;
    if (cmd_q.size() - base != 34) begin
      errors++; $display("FAIL refresh_cmd_count: got %0d want 34", cmd_q.size() - base);
    end
    if (cmd_q.size() >= base + 34) begin
      for (int j = 0; j < 34; j++) begin
        checks++;
        if (cmd_q[base + j] !== frame_cmd(j)) begin
          errors++; $display("FAIL refresh_cmd[%0d]: got %h want %h", j, cmd_q[base + j], frame_cmd(j));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int base = cmd_q.size();
    int f0 = frame_cnt;
    pulse_refresh();
    repeat (50) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      pulse_refresh();
      repeat (20) @(negedge clk);
    end
    for (int i = 0; i < 3000 && frame_cnt < f0 + 2; i++) @(negedge clk);
    repeat (600) @(negedge clk);
    checks++;
    if (frame_cnt != f0 + 2) begin
      errors++; $display("FAIL coalesce_frames: got %0d want 2", frame_cnt - f0);
    end
    checks++;
    if (cmd_q.size() - base != 68) begin
      errors++; $display("FAIL coalesce_cmd_count: got %0d want 68", cmd_q.size() - base);
    end
    if (cmd_q.size() >= base + 68) begin
      checks++;
      if (cmd_q[base + 34] !== 10'h080) begin
        errors++; $display("FAIL coalesce_second_start: got %h want 080", cmd_q[base + 34]);
      end
    end
  endtask

  task automatic test_refresh_at_done();
    int base = cmd_q.size();
    int f0 = frame_cnt;
    int n = 0;
    pulse_refresh();
    while (!(instr_done && cmd_q.size() >= base + 34) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 2000) begin
      errors++; $display("FAIL done_edge_timeout: got %0d cycles want <2000", n);
    end
    @(negedge clk);
    refresh = 1'b1;
    checks++;
    if (frame_done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL done_edge_pulse: got fd=%b busy=%b want 1/0", frame_done, busy);
    end
    @(negedge clk);
    refresh = 1'b0;
    checks++;
    if (instr_next !== 1'b0) begin
      errors++; $display("FAIL done_edge_idle: got instr_next=%b want 0", instr_next);
    end
    @(negedge clk);
    checks++;
    if (instr_next !== 1'b1 || instr_db !== 10'h080) begin
      errors++; $display("FAIL done_edge_restart: got %b/%h want 1/080", instr_next, instr_db);
    end
    for (int i = 0; i < 2000 && frame_cnt < f0 + 2; i++) @(negedge clk);
    repeat (600) @(negedge clk);
    checks++;
    if (frame_cnt != f0 + 2) begin
      errors++; $display("FAIL done_edge_frames: got %0d want 2", frame_cnt - f0);
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] cfg_exp[4];
    int base = cmd_q.size();
    int b2;
    cfg_exp[0] = 10'h028; cfg_exp[1] = 10'h006; cfg_exp[2] = 10'h00C; cfg_exp[3] = 10'h001;
    pulse_refresh();
    for (int i = 0; i < 500 && cmd_q.size() < base + 8; i++) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (instr_db !== 10'h000 || instr_next !== 1'b0 || char_addr !== 5'd0) begin
      errors++;
      $display("FAIL mid_reset_cmd: got db=%h next=%b addr=%h want 000/0/00",
               instr_db, instr_next, char_addr);
    end
    checks++;
    if (busy !== 1'b0 || frame_done !== 1'b0) begin
      errors++; $display("FAIL mid_reset_status: got busy=%b fd=%b want 0/0", busy, frame_done);
    end
    repeat (2) @(negedge clk);
    b2 = cmd_q.size();
    reset = 1'b1;
    for (int i = 0; i < 200 && cmd_q.size() < b2 + 4; i++) @(negedge clk);
    checks++;
    if (cmd_q.size() < b2 + 4) begin
      errors++; $display("FAIL restart_count: got %0d want 4", cmd_q.size() - b2);
    end else begin
      for (int j = 0; j < 4; j++) begin
        checks++;
        if (cmd_q[b2 + j] !== cfg_exp[j]) begin
          errors++; $display("FAIL restart_cmd[%0d]: got %h want %h", j, cmd_q[b2 + j], cfg_exp[j]);
        end
      end
    end
  endtask

  task automatic test_protocol();
    checks++;
    if (viol != 0) begin
      errors++; $display("FAIL handshake_protocol: got %0d violations want 0", viol);
    end
  endtask

  initial begin
    test_reset();
    test_init_frame();
    test_refresh_idle();
    test_back_to_back();
    test_refresh_at_done();
    test_reset_mid();
    test_protocol();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
